textmem_arb: RTL and testbench
==============================

TEXTMEM_ARB -- requirements
Module: textmem_arb

Interface
REQ-001 Parameter: ADDR_W, 12, word-address width of text RAM (4096 x 32-bit words).
REQ-002 Parameter: STARVE_LIMIT, 4, consecutive contested video grants before the CPU is forced a grant.
REQ-003 clk_i  in  1  single system clock; all logic on its rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-low.
REQ-005 cpu_cyc_i  in  1  CPU request, held until cpu_ack_o.
REQ-006 cpu_we_i  in  1  1 = write, 0 = read.
REQ-007 cpu_sel_i  in  4  byte-lane enables for writes; bit 3 = dat[31:24].
REQ-008 cpu_adr_i  in  32  CPU byte address; bits [ADDR_W+1:2] used.
REQ-009 cpu_dat_i  in  32  CPU write data.
REQ-010 cpu_dat_o  out  32  CPU read data, valid while cpu_ack_o=1.
REQ-011 cpu_ack_o  out  1  one-cycle CPU completion pulse.
REQ-012 vid_cyc_i  in  1  text-driver fetch request, held until vid_ack_o.
REQ-013 vid_adr_i  in  32  text-driver byte address; bits [ADDR_W+1:2] used.
REQ-014 vid_dat_o  out  32  fetched word (two chars: {color0,char0,color1,char1}), valid while vid_ack_o=1.
REQ-015 vid_ack_o  out  1  one-cycle video completion pulse.

Function
REQ-016 FSM states SHALL be IDLE, ACK_V, ACK_C; transitions only IDLE->ACK_V, IDLE->ACK_C, ACK_x->IDLE.
REQ-017 In IDLE with exactly one cyc asserted, that requester SHALL be granted; RAM address/enable driven combinationally from its adr in the same cycle.
REQ-018 Both cyc asserted in IDLE: video SHALL win unless starve counter == STARVE_LIMIT, then CPU wins.
REQ-019 Starve counter (3 bits) SHALL increment on each video grant while cpu_cyc_i=1, clear on CPU grant or whenever cpu_cyc_i=0, saturate at STARVE_LIMIT.
REQ-020 Latency: request granted in IDLE cycle N SHALL produce ack in cycle N+1 (ACK_x); next grant earliest in cycle N+2.
REQ-021 In ACK_V: vid_ack_o=1, vid_dat_o = RAM word; in ACK_C: cpu_ack_o=1, cpu_dat_o = RAM word (reads) or don't-care (writes).
REQ-022 CPU write SHALL commit at the IDLE->ACK_C edge, only lanes with cpu_sel_i=1; cpu_sel_i=0000 commits nothing but still acks.
REQ-023 In ACK_x no new request SHALL be sampled; cyc still asserted there is re-arbitrated in the following IDLE.
REQ-024 Acks SHALL never be asserted simultaneously and each SHALL last exactly one cycle.
REQ-025 Address bits above [ADDR_W+1:2] and [1:0] SHALL be ignored (aliasing, no error).
REQ-026 cyc dropped before ack: ack SHALL still pulse in ACK_x; write still commits.
REQ-027 Output data SHALL be 0 when the corresponding ack is 0.

Reset
REQ-028 rst_i low SHALL asynchronously force state=IDLE, starve counter=0, cpu_ack_o=0, vid_ack_o=0, cpu_dat_o=0, vid_dat_o=0.
REQ-029 Reset mid-transaction SHALL abort without ack; a write already committed stays; RAM contents are not cleared.
REQ-030 First grant possible in the first clk_i cycle after rst_i deasserts.

Structure
REQ-031 Shared package SHALL hold the state enum (IDLE/ACK_V/ACK_C) and the default ADDR_W/STARVE_LIMIT constants.
REQ-032 One sub-module textram: single-port synchronous RAM, 2**ADDR_W x 32, byte-write enables, 1-cycle registered read.

Verification
REQ-033 Reset, CPU write adr 0x10 data 0x41074207 sel 1111, then video read adr 0x10 -> vid_ack_o one cycle after grant, vid_dat_o=0x41074207.
REQ-034 Word 0x20 = 0xFFFFFFFF; CPU write sel 0100 data 0x00AB0000 -> CPU read 0x20 returns 0xFFABFFFF.
REQ-035 Both cyc held continuously -> 4 video acks, then 1 CPU ack, pattern repeats; never two acks same cycle.
REQ-036 Video cyc only, back-to-back adr 0,4,8 -> acks in cycles 1,3,5 relative to first grant.
REQ-037 rst_i low during ACK_V -> vid_ack_o 0 immediately, state IDLE; prior RAM data readable after reset.
REQ-038 CPU write adr 0x10010 -> aliases word 0x4 (ADDR_W=12); video read adr 0x10 returns written value.

Source files
------------

// File: rtl/textmem_arb_pkg.sv
// Shared types and default sizing for the text-memory arbiter.
// The state enum is also exported on the arbiter's debug port.
package textmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK_V = 2'd1,
    ACK_C = 2'd2
  } arb_state_t;

  localparam int ADDR_W_DEF       = 12;
  localparam int STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/textmem_arb_textram.sv
// Single-port text RAM, 2**ADDR_W x 32 bits, byte-lane writes, registered read.
// Contents are deliberately not reset so screen text survives an arbiter reset.
module textram #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/textmem_arb.sv
// Arbitrates a CPU port and a text-driver fetch port onto one text RAM.
// Video has priority; a starve counter forces a CPU grant after STARVE_LIMIT contested video wins.
module textmem_arb
  import textmem_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cpu_cyc_i,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic [31:0] cpu_adr_i,
  input  logic [31:0] cpu_dat_i,
  output logic [31:0] cpu_dat_o,
  output logic        cpu_ack_o,
  input  logic        vid_cyc_i,
  input  logic [31:0] vid_adr_i,
  output logic [31:0] vid_dat_o,
  output logic        vid_ack_o,
  output arb_state_t  state_o
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  arb_state_t        state, state_nxt;
  logic [2:0]        starve, starve_nxt;
  logic              grant_v, grant_c;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_rdata;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= IDLE;
      starve <= '0;
    end else begin
      state  <= state_nxt;
      starve <= starve_nxt;
    end
  end

  // Requests are only sampled in IDLE; every ACK state returns to IDLE.
  always_comb begin
    grant_v   = 1'b0;
    grant_c   = 1'b0;
    state_nxt = IDLE;
    if (state == IDLE) begin
      if (vid_cyc_i && !(cpu_cyc_i && starve == LIMIT)) grant_v = 1'b1;
      else if (cpu_cyc_i)                               grant_c = 1'b1;
      if (grant_v)      state_nxt = ACK_V;
      else if (grant_c) state_nxt = ACK_C;
    end

    starve_nxt = starve;
    if (!cpu_cyc_i || grant_c)        starve_nxt = '0;
    else if (grant_v && starve < LIMIT) starve_nxt = starve + 3'd1;
  end

  assign ram_en   = grant_v | grant_c;
  assign ram_we   = grant_c & cpu_we_i;
  assign ram_addr = grant_c ? cpu_adr_i[ADDR_W+1:2] : vid_adr_i[ADDR_W+1:2];

  textram #(.ADDR_W(ADDR_W)) u_textram (
    .clk   (clk_i),
    .en    (ram_en),
    .we    (ram_we),
    .be    (cpu_sel_i),
    .addr  (ram_addr),
    .wdata (cpu_dat_i),
    .rdata (ram_rdata)
  );

  assign vid_ack_o = (state == ACK_V);
  assign cpu_ack_o = (state == ACK_C);
  assign vid_dat_o = vid_ack_o ? ram_rdata : 32'h0;
  assign cpu_dat_o = cpu_ack_o ? ram_rdata : 32'h0;
  assign state_o   = state;

  // Upper and byte-offset address bits alias by design.
  logic unused_adr;
  assign unused_adr = ^{cpu_adr_i[31:ADDR_W+2], cpu_adr_i[1:0],
                        vid_adr_i[31:ADDR_W+2], vid_adr_i[1:0]};

endmodule

// File: tb/tb_textmem_arb.sv
// Bench for textmem_arb: directed scenarios plus randomized traffic,
// checked against a transaction-level model (grant rules, word memory, expected queues).
module tb_textmem_arb;
  import textmem_arb_pkg::*;

  localparam int LIM = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cpu_cyc_i, cpu_we_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_adr_i, cpu_dat_i, cpu_dat_o;
  logic        cpu_ack_o;
  logic        vid_cyc_i;
  logic [31:0] vid_adr_i, vid_dat_o;
  logic        vid_ack_o;
  arb_state_t  state_o;

  always #5 clk_i = ~clk_i;

  textmem_arb #(.ADDR_W(12), .STARVE_LIMIT(LIM)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .cpu_cyc_i (cpu_cyc_i),
    .cpu_we_i  (cpu_we_i),
    .cpu_sel_i (cpu_sel_i),
    .cpu_adr_i (cpu_adr_i),
    .cpu_dat_i (cpu_dat_i),
    .cpu_dat_o (cpu_dat_o),
    .cpu_ack_o (cpu_ack_o),
    .vid_cyc_i (vid_cyc_i),
    .vid_adr_i (vid_adr_i),
    .vid_dat_o (vid_dat_o),
    .vid_ack_o (vid_ack_o),
    .state_o   (state_o)
  );

  // Reference model state
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] ref_mem [4096];
  int          starve_m = 0;
  int          pend_now = 0;   // 0 none, 1 video ack showing, 2 cpu ack showing
  logic [31:0] vid_exp_q [$];
  logic [31:0] cpu_exp_q [$];
  logic        cpu_rd_q  [$];
  logic [31:0] last_vid, last_cpu;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rand_adr();
    logic [31:0] a;
    a = ($urandom() & 32'hFFFF_C000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
    return a;
  endfunction

  // Advance one clock: model the grant decision for the current inputs, then check outputs.
  task automatic tick();
    int          g;
    logic [11:0] idx;
    logic [31:0] exp_d;
    logic        rd;
    g = 0;
    if (pend_now == 0) begin
      if (vid_cyc_i && !(cpu_cyc_i && starve_m == LIM)) g = 1;
      else if (cpu_cyc_i)                               g = 2;
    end
    if (!cpu_cyc_i || g == 2)        starve_m = 0;
    else if (g == 1 && starve_m < LIM) starve_m++;
    if (g == 1) vid_exp_q.push_back(ref_mem[vid_adr_i[13:2]]);
    if (g == 2) begin
      idx = cpu_adr_i[13:2];
      cpu_exp_q.push_back(ref_mem[idx]);
      cpu_rd_q.push_back(!cpu_we_i);
      if (cpu_we_i)
        for (int b = 0; b < 4; b++)
          if (cpu_sel_i[b]) ref_mem[idx][8*b +: 8] = cpu_dat_i[8*b +: 8];
    end
    @(posedge clk_i);
    @(negedge clk_i);
    pend_now = g;
    check("vid_ack", 32'(vid_ack_o), 32'(pend_now == 1));
    check("cpu_ack", 32'(cpu_ack_o), 32'(pend_now == 2));
    check("state", 32'(state_o), (pend_now == 1) ? 32'(ACK_V) : (pend_now == 2) ? 32'(ACK_C) : 32'(IDLE));
    if (pend_now == 1) begin
      exp_d = vid_exp_q.pop_front();
      check("vid_dat", vid_dat_o, exp_d);
      last_vid = vid_dat_o;
    end else begin
      check("vid_dat_idle", vid_dat_o, 32'h0);
    end
    if (pend_now == 2) begin
      exp_d = cpu_exp_q.pop_front();
      rd    = cpu_rd_q.pop_front();
      if (rd) check("cpu_dat", cpu_dat_o, exp_d);
      last_cpu = cpu_dat_o;
    end else begin
      check("cpu_dat_idle", cpu_dat_o, 32'h0);
    end
  endtask

  task automatic cpu_xfer(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                          input logic [31:0] dat, output int lat);
    cpu_cyc_i = 1'b1; cpu_we_i = we; cpu_sel_i = sel; cpu_adr_i = adr; cpu_dat_i = dat;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      tick(); lat++;
      if (pend_now == 2) break;
    end
    if (pend_now != 2) check("cpu_timeout", 32'(pend_now), 32'd2);
    cpu_cyc_i = 1'b0;
    tick();
  endtask

  task automatic vid_read(input logic [31:0] adr, output int lat);
    vid_cyc_i = 1'b1; vid_adr_i = adr;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      tick(); lat++;
      if (pend_now == 1) break;
    end
    if (pend_now != 1) check("vid_timeout", 32'(pend_now), 32'd1);
    vid_cyc_i = 1'b0;
    tick();
  endtask

  initial begin
    int          lat;
    int          ack_k [3];
    int          na;
    logic [31:0] saved;

    rst_i = 1'b0;
    cpu_cyc_i = 0; cpu_we_i = 0; cpu_sel_i = 0; cpu_adr_i = 0; cpu_dat_i = 0;
    vid_cyc_i = 0; vid_adr_i = 0;
    repeat (2) @(negedge clk_i);
    check("rst_vid_ack", 32'(vid_ack_o), 32'd0);
    check("rst_cpu_ack", 32'(cpu_ack_o), 32'd0);
    check("rst_vid_dat", vid_dat_o, 32'h0);
    check("rst_cpu_dat", cpu_dat_o, 32'h0);
    check("rst_state", 32'(state_o), 32'(IDLE));
    rst_i = 1'b1;

    // Write then fetch; first grant lands in the first cycle after reset release.
    cpu_xfer(32'h10, 1'b1, 4'hF, 32'h4107_4207, lat);
    check("first_grant_lat", 32'(lat), 32'd1);
    vid_read(32'h10, lat);
    check("vid_lat", 32'(lat), 32'd1);
    check("vid_word_0x10", last_vid, 32'h4107_4207);

    for (int w = 0; w < 16; w++) cpu_xfer(32'(w) << 2, 1'b1, 4'hF, $urandom(), lat);

    // Byte-lane merge
    cpu_xfer(32'h20, 1'b1, 4'hF, 32'hFFFF_FFFF, lat);
    cpu_xfer(32'h20, 1'b1, 4'b0100, 32'h00AB_0000, lat);
    cpu_xfer(32'h20, 1'b0, 4'h0, 32'h0, lat);
    check("lane_merge", last_cpu, 32'hFFAB_FFFF);
    cpu_xfer(32'h20, 1'b1, 4'b0000, 32'h1234_5678, lat);
    cpu_xfer(32'h20, 1'b0, 4'h0, 32'h0, lat);
    check("sel_none", last_cpu, 32'hFFAB_FFFF);

    // Aliased CPU address
    cpu_xfer(32'h0001_0010, 1'b1, 4'hF, 32'hCAFE_0123, lat);
    vid_read(32'h10, lat);
    check("alias", last_vid, 32'hCAFE_0123);

    // Back-to-back video fetches
    na = 0;
    vid_cyc_i = 1'b1; vid_adr_i = 32'h0;
    for (int k = 1; k <= 8 && na < 3; k++) begin
      tick();
      if (pend_now == 1) begin
        ack_k[na] = k; na++;
        vid_adr_i = 32'(na) << 2;
        if (na == 3) vid_cyc_i = 1'b0;
      end
    end
    check("b2b_count", 32'(na), 32'd3);
    for (int i = 0; i < 3; i++) check("b2b_cycle", 32'(ack_k[i]), 32'(2 * i + 1));
    vid_cyc_i = 1'b0;
    tick();

    // Continuous contention: 4 video acks then 1 cpu ack, repeating
    tick();
    vid_cyc_i = 1'b1; vid_adr_i = 32'h8;
    cpu_cyc_i = 1'b1; cpu_we_i = 1'b0; cpu_adr_i = 32'h4;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k % 2 == 1) begin
        check("starve_vid", 32'(vid_ack_o), 32'((((k + 1) / 2) % 5) != 0));
        check("starve_cpu", 32'(cpu_ack_o), 32'((((k + 1) / 2) % 5) == 0));
      end
      check("ack_exclusive", 32'(vid_ack_o & cpu_ack_o), 32'd0);
    end
    vid_cyc_i = 1'b0; cpu_cyc_i = 1'b0;
    tick();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      if (!vid_cyc_i || pend_now == 1) begin
        vid_cyc_i = ($urandom_range(0, 2) != 0);
        vid_adr_i = rand_adr();
      end
      if (!cpu_cyc_i || pend_now == 2) begin
        cpu_cyc_i = ($urandom_range(0, 2) != 0);
        cpu_we_i  = $urandom_range(0, 1) != 0;
        cpu_sel_i = 4'($urandom_range(0, 15));
        cpu_adr_i = rand_adr();
        cpu_dat_i = $urandom();
      end
      tick();
      check("ack_exclusive", 32'(vid_ack_o & cpu_ack_o), 32'd0);
    end
    vid_cyc_i = 1'b0; cpu_cyc_i = 1'b0;
    tick(); tick();

    // Reset during ACK_V aborts the ack but keeps RAM
    saved = ref_mem[4];
    vid_cyc_i = 1'b1; vid_adr_i = 32'h10;
    tick();
    check("pre_rst_in_ackv", 32'(state_o), 32'(ACK_V));
    rst_i = 1'b0;
    #1;
    check("rst_mid_vid_ack", 32'(vid_ack_o), 32'd0);
    check("rst_mid_vid_dat", vid_dat_o, 32'h0);
    check("rst_mid_state", 32'(state_o), 32'(IDLE));
    vid_cyc_i = 1'b0;
    pend_now = 0; starve_m = 0;
    vid_exp_q.delete(); cpu_exp_q.delete(); cpu_rd_q.delete();
    @(negedge clk_i);
    rst_i = 1'b1;
    vid_read(32'h10, lat);
    check("post_rst_lat", 32'(lat), 32'd1);
    check("post_rst_data", last_vid, saved);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
